ft245_channel_mux: RTL and testbench

Framed command demultiplexer between the FT245 FIFO simple interface and N downstream channels (modulators, controller). It parses host frames of the form sync, channel, length, payload and optional checksum. Payload bytes are forwarded to the addressed channel with per-byte backpressure, and one status byte per frame is returned to the host over the TX simple interface. It replaces the single-consumer controller hookup and generalises it to a parametrised channel count with timeout and error reporting.

---
 rtl/ft245_channel_mux_pkg.sv | 23 ++
 rtl/ft245_channel_mux_if.sv | 31 +++
 rtl/ft245_channel_mux_link_timeout.sv | 34 +++
 rtl/ft245_channel_mux.sv | 259 +++++++++++++++++++++++++
 tb/tb_ft245_channel_mux.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/ft245_channel_mux_pkg.sv
// ft245_pkg: shared definitions for the FT245 framed channel demultiplexer.
//   - state_t and S_* : FSM state encodings.
//   - ST_*            : status codes returned to the host, one per frame.
//   - DEF_SYNC_BYTE   : default frame start marker.
package ft245_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_CHAN    = 3'd1;
    localparam state_t S_LEN     = 3'd2;
    localparam state_t S_PAYLOAD = 3'd3;
    localparam state_t S_CSUM    = 3'd4;
    localparam state_t S_STATUS  = 3'd5;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_BAD_CH  = 8'h01;
    localparam logic [7:0] ST_TIMEOUT = 8'h02;
    localparam logic [7:0] ST_CSUM    = 8'h03;

    localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/ft245_channel_mux_if.sv
// ft245_channel_mux_if: bundle of the host-side FT245 simple interface and the
// downstream channel bus.
//   rx_data_si/rx_rdy_si/rx_ack_si : received byte, byte available, consume pulse
//   tx_data_si/tx_rdy_si/tx_ack_si : status byte, byte valid, host accepted
//   ch_data/ch_valid/ch_ready      : shared payload byte, one-hot valid, per-channel ready
// Modports: slave = the demultiplexer, master = the host/channel side.
interface ft245_channel_mux_if #(
    parameter int unsigned N_CHANNELS = 4
) ();

    logic [7:0]            rx_data_si;
    logic                  rx_rdy_si;
    logic                  rx_ack_si;
    logic [7:0]            tx_data_si;
    logic                  tx_rdy_si;
    logic                  tx_ack_si;
    logic [7:0]            ch_data;
    logic [N_CHANNELS-1:0] ch_valid;
    logic [N_CHANNELS-1:0] ch_ready;

    modport slave (
        input  rx_data_si, rx_rdy_si, tx_ack_si, ch_ready,
        output rx_ack_si, tx_data_si, tx_rdy_si, ch_data, ch_valid
    );

    modport master (
        output rx_data_si, rx_rdy_si, tx_ack_si, ch_ready,
        input  rx_ack_si, tx_data_si, tx_rdy_si, ch_data, ch_valid
    );

endinterface

// File: rtl/ft245_channel_mux_link_timeout.sv
// link_timeout: inter-byte gap counter.
//   clk, rst   : clock, asynchronous active-high reset
//   i_clear    : synchronous clear (priority over enable)
//   i_enable   : count one cycle
//   o_expired  : counter has reached TIMEOUT_CYCLES (holds there until cleared)
module link_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1280000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_count;
    logic          w_expired;

    assign w_expired = (r_count == CW'(TIMEOUT_CYCLES));
    assign o_expired = w_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !w_expired) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/ft245_channel_mux.sv
// ft245_channel_mux: parses host frames (sync, channel, length, payload
// [, checksum]) from the FT245 rx side, forwards payload bytes to the addressed
// channel with per-byte backpressure and returns one status byte per frame.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ft245_channel_mux_if.slave (rx/tx simple interface + channel bus)
//   leds     : low 8 bits of the good-frame counter
// Build option: define CHECKSUM_EN to expect a trailing XOR checksum byte.
module ft245_channel_mux
    import ft245_pkg::*;
#(
    parameter int unsigned N_CHANNELS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1280000,
    parameter logic [7:0]  SYNC_BYTE      = DEF_SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 rst,
    ft245_channel_mux_if.slave   bus,
    output logic [7:0]           leds
);

    state_t                r_state, w_state_nxt;
    logic [7:0]            r_ch_id, w_ch_id_nxt;
    logic                  r_bad, w_bad_nxt;
    logic [7:0]            r_len_rem, w_len_nxt;
    logic [7:0]            r_status, w_status_nxt;
    logic [7:0]            r_ch_data, w_ch_data_nxt;
    logic [N_CHANNELS-1:0] r_ch_valid, w_ch_valid_nxt;
    logic                  r_rx_ack, w_rx_ack_nxt;
    logic                  r_tx_rdy, w_tx_rdy_nxt;
    logic [7:0]            r_tx_data, w_tx_data_nxt;
    logic [7:0]            r_good_cnt, w_good_nxt;

    logic [N_CHANNELS-1:0] w_sel;
    logic                  w_in_frame;
    logic                  w_drain;
    logic                  w_reg_free;
    logic                  w_can_accept;
    logic                  w_accept;
    logic                  w_pay_hold;
    logic                  w_tmo_en;
    logic                  w_tmo_clear;
    logic                  w_expired;
    logic                  w_goto_end;

    // One-hot decode of the latched channel id; ids >= N_CHANNELS decode to 0.
    always_comb begin
        w_sel = '0;
        for (int unsigned i = 0; i < N_CHANNELS; i++) begin
            w_sel[i] = (r_ch_id == 8'(i));
        end
    end

    assign w_in_frame = (r_state == S_CHAN) || (r_state == S_LEN) ||
                        (r_state == S_PAYLOAD) || (r_state == S_CSUM);

    // Output register is being consumed on this edge.
    assign w_drain    = |(r_ch_valid & bus.ch_ready);
    assign w_reg_free = !(|r_ch_valid) || w_drain;

    always_comb begin
        w_can_accept = 1'b0;
        case (r_state)
            S_IDLE, S_CHAN, S_LEN: w_can_accept = 1'b1;
            S_PAYLOAD:             w_can_accept = (r_len_rem != 8'd0) && (r_bad || w_reg_free);
`ifdef CHECKSUM_EN
            S_CSUM:                w_can_accept = 1'b1;
`endif
            default:               w_can_accept = 1'b0;
        endcase
    end

    // The ack is registered, so a byte is never acked on consecutive cycles.
    assign w_accept = bus.rx_rdy_si && !r_rx_ack && w_can_accept && !w_expired;

    // Gap timer is frozen while the payload waits on the channel side.
    assign w_pay_hold  = (r_state == S_PAYLOAD) && ((|r_ch_valid) || (r_len_rem == 8'd0));
    assign w_tmo_en    = w_in_frame && !r_rx_ack && !bus.rx_rdy_si && !w_pay_hold;
    assign w_tmo_clear = r_rx_ack || !w_in_frame;

    link_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_link_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_tmo_clear),
        .i_enable  (w_tmo_en),
        .o_expired (w_expired)
    );

`ifdef CHECKSUM_EN
    logic [7:0] r_csum, w_csum_nxt;

    // Running XOR over channel, length and payload bytes as they are captured.
    always_comb begin
        w_csum_nxt = r_csum;
        if (r_rx_ack) begin
            case (r_state)
                S_CHAN:           w_csum_nxt = bus.rx_data_si;
                S_LEN, S_PAYLOAD: w_csum_nxt = r_csum ^ bus.rx_data_si;
                default:          w_csum_nxt = r_csum;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= 8'd0;
        end else begin
            r_csum <= w_csum_nxt;
        end
    end
`endif

    // A byte is captured in the cycle its ack is high (r_rx_ack).
    always_comb begin
        w_state_nxt    = r_state;
        w_ch_id_nxt    = r_ch_id;
        w_bad_nxt      = r_bad;
        w_len_nxt      = r_len_rem;
        w_status_nxt   = r_status;
        w_ch_data_nxt  = r_ch_data;
        w_ch_valid_nxt = r_ch_valid;
        w_rx_ack_nxt   = w_accept;
        w_tx_rdy_nxt   = r_tx_rdy;
        w_tx_data_nxt  = r_tx_data;
        w_good_nxt     = r_good_cnt;
        w_goto_end     = 1'b0;

        if (w_drain) begin
            w_ch_valid_nxt = '0;
        end

        if (w_in_frame && w_expired) begin
            // Timeout overrides any earlier error code.
            w_state_nxt    = S_STATUS;
            w_status_nxt   = ST_TIMEOUT;
            w_ch_valid_nxt = '0;
            w_rx_ack_nxt   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_rx_ack && (bus.rx_data_si == SYNC_BYTE)) begin
                        w_state_nxt  = S_CHAN;
                        w_status_nxt = ST_OK;
                        w_bad_nxt    = 1'b0;
                    end
                end
                S_CHAN: begin
                    if (r_rx_ack) begin
                        w_ch_id_nxt = bus.rx_data_si;
                        w_state_nxt = S_LEN;
                        if (32'(bus.rx_data_si) >= N_CHANNELS) begin
                            w_bad_nxt    = 1'b1;
                            w_status_nxt = ST_BAD_CH;
                        end
                    end
                end
                S_LEN: begin
                    if (r_rx_ack) begin
                        w_len_nxt = bus.rx_data_si;
                        if (bus.rx_data_si == 8'd0) begin
                            w_goto_end = 1'b1;
                        end else begin
                            w_state_nxt = S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (r_rx_ack) begin
                        w_len_nxt = r_len_rem - 8'd1;
                        if (!r_bad) begin
                            w_ch_data_nxt  = bus.rx_data_si;
                            w_ch_valid_nxt = w_sel;
                        end else if (r_len_rem == 8'd1) begin
                            // Discarded bytes need no drain; leave right away.
                            w_goto_end = 1'b1;
                        end
                    end else if ((r_len_rem == 8'd0) && w_reg_free) begin
                        w_goto_end = 1'b1;
                    end
                end
`ifdef CHECKSUM_EN
                S_CSUM: begin
                    if (r_rx_ack) begin
                        w_state_nxt = S_STATUS;
                        // An earlier bad-channel code is kept.
                        if ((bus.rx_data_si != r_csum) && (r_status == ST_OK)) begin
                            w_status_nxt = ST_CSUM;
                        end
                    end
                end
`endif
                S_STATUS: begin
                    if (r_tx_rdy && bus.tx_ack_si) begin
                        w_state_nxt   = S_IDLE;
                        w_tx_rdy_nxt  = 1'b0;
                        w_tx_data_nxt = 8'd0;
                        if (r_status == ST_OK) begin
                            w_good_nxt = r_good_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase

            if (w_goto_end) begin
`ifdef CHECKSUM_EN
                w_state_nxt = S_CSUM;
`else
                w_state_nxt = S_STATUS;
`endif
            end
        end

        // Present the status byte on the edge that enters STATUS.
        if ((w_state_nxt == S_STATUS) && (r_state != S_STATUS)) begin
            w_tx_rdy_nxt  = 1'b1;
            w_tx_data_nxt = w_status_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ch_id    <= 8'd0;
            r_bad      <= 1'b0;
            r_len_rem  <= 8'd0;
            r_status   <= ST_OK;
            r_ch_data  <= 8'd0;
            r_ch_valid <= '0;
            r_rx_ack   <= 1'b0;
            r_tx_rdy   <= 1'b0;
            r_tx_data  <= 8'd0;
            r_good_cnt <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_ch_id    <= w_ch_id_nxt;
            r_bad      <= w_bad_nxt;
            r_len_rem  <= w_len_nxt;
            r_status   <= w_status_nxt;
            r_ch_data  <= w_ch_data_nxt;
            r_ch_valid <= w_ch_valid_nxt;
            r_rx_ack   <= w_rx_ack_nxt;
            r_tx_rdy   <= w_tx_rdy_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_good_cnt <= w_good_nxt;
        end
    end

    assign bus.rx_ack_si  = r_rx_ack;
    assign bus.tx_rdy_si  = r_tx_rdy;
    assign bus.tx_data_si = r_tx_data;
    assign bus.ch_data    = r_ch_data;
    assign bus.ch_valid   = r_ch_valid;
    assign leds           = r_good_cnt;

endmodule

// File: tb/tb_ft245_channel_mux.sv
// Testbench for ft245_channel_mux: table of whole frames plus hand-written
// sequences for backpressure, timeout and mid-frame reset.
module tb_ft245_channel_mux;
    import ft245_pkg::*;

    localparam int unsigned N_CH   = 4;
    localparam int unsigned TB_TMO = 300;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] leds;

    ft245_channel_mux_if #(.N_CHANNELS(N_CH)) bus ();

    ft245_channel_mux #(
        .N_CHANNELS     (N_CH),
        .TIMEOUT_CYCLES (TB_TMO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .leds (leds)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Delivery log and rx_ack spacing monitor.
    logic [7:0]      dlv_data [0:255];
    logic [N_CH-1:0] dlv_vec  [0:255];
    int              dlv_n    = 0;
    int              ack_viol = 0;
    logic            prev_ack = 1'b0;

    always @(negedge clk) begin
        if ((bus.ch_valid & bus.ch_ready) != '0) begin
            dlv_data[dlv_n[7:0]] <= bus.ch_data;
            dlv_vec[dlv_n[7:0]]  <= bus.ch_valid;
            dlv_n                <= dlv_n + 1;
        end
        if (bus.rx_ack_si && prev_ack) ack_viol <= ack_viol + 1;
        prev_ack <= bus.rx_ack_si;
    end

    typedef struct {
        logic [63:0]     frame;    // bytes sent MSB first
        int              len;
        logic [31:0]     exp_data; // delivered bytes MSB first
        int              exp_n;
        logic [N_CH-1:0] exp_vec;
        logic [7:0]      exp_st;
        logic [7:0]      exp_leds;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic present(input logic [7:0] b);
        bus.rx_data_si = b;
        bus.rx_rdy_si  = 1'b1;
    endtask

    task automatic wait_ack(input int bound, input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (bus.rx_ack_si) seen = 1'b1;
        end
        chk({nm, " rx_ack"}, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
        bus.rx_rdy_si = 1'b0;
    endtask

    task automatic send_frame(input logic [63:0] fr, input int len, input string nm);
        for (int k = 0; k < len; k++) begin
            present(fr[63 - 8 * k -: 8]);
            wait_ack(200, nm);
        end
    endtask

    task automatic finish_status(input logic [7:0] exp_st, input logic [7:0] exp_leds,
                                 input string nm, input int bound, output int cyc);
        cyc = 0;
        while (!bus.tx_rdy_si && cyc < bound) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, " tx_rdy"}, 32'(bus.tx_rdy_si), 32'd1);
        chk({nm, " status"}, 32'(bus.tx_data_si), 32'(exp_st));
        repeat (3) @(negedge clk);
        chk({nm, " tx held"}, 32'({bus.tx_rdy_si, bus.tx_data_si}), 32'({1'b1, exp_st}));
        @(posedge clk);
        #1 bus.tx_ack_si = 1'b1;
        @(posedge clk);
        #1 bus.tx_ack_si = 1'b0;
        @(negedge clk);
        chk({nm, " tx cleared"}, 32'({bus.tx_rdy_si, bus.tx_data_si}), 32'd0);
        chk({nm, " leds"}, 32'(leds), 32'(exp_leds));
    endtask

    task automatic check_dlv(input int start, input int n, input logic [31:0] data,
                             input logic [N_CH-1:0] vec, input string nm);
        chk({nm, " dlv count"}, 32'(dlv_n - start), 32'(n));
        for (int k = 0; k < n && k < dlv_n - start; k++) begin
            chk($sformatf("%s dlv%0d", nm, k),
                32'({dlv_vec[8'(start + k)], dlv_data[8'(start + k)]}),
                32'({vec, data[31 - 8 * k -: 8]}));
        end
    endtask

    initial begin
        int   cyc;
        int   start;
        int   bad;
        logic [7:0] base;

`ifdef CHECKSUM_EN
        vecs[0] = '{64'hA5_01_03_11_22_33_02_00, 7, 32'h11_22_33_00, 3, 4'b0010, ST_OK,     8'd1};
        vecs[1] = '{64'hA5_07_02_AA_BB_00_00_00, 6, 32'h0,           0, 4'b0000, ST_BAD_CH, 8'd1};
        vecs[2] = '{64'hA5_01_01_10_FF_00_00_00, 5, 32'h10_00_00_00, 1, 4'b0010, ST_CSUM,   8'd1};
        vecs[3] = '{64'h3C_A5_03_00_03_00_00_00, 5, 32'h0,           0, 4'b1000, ST_OK,     8'd2};
`else
        vecs[0] = '{64'hA5_01_03_11_22_33_00_00, 6, 32'h11_22_33_00, 3, 4'b0010, ST_OK,     8'd1};
        vecs[1] = '{64'hA5_07_02_AA_BB_00_00_00, 5, 32'h0,           0, 4'b0000, ST_BAD_CH, 8'd1};
        vecs[2] = '{64'hA5_01_01_10_00_00_00_00, 4, 32'h10_00_00_00, 1, 4'b0010, ST_OK,     8'd2};
        vecs[3] = '{64'h3C_A5_03_00_00_00_00_00, 4, 32'h0,           0, 4'b1000, ST_OK,     8'd3};
`endif

        rst            = 1'b1;
        bus.rx_data_si = 8'd0;
        bus.rx_rdy_si  = 1'b0;
        bus.tx_ack_si  = 1'b0;
        bus.ch_ready   = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs",
            32'({bus.rx_ack_si, bus.tx_rdy_si, bus.tx_data_si, bus.ch_valid, bus.ch_data}), 32'd0);
        chk("reset leds", 32'(leds), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle outputs",
            32'({bus.rx_ack_si, bus.tx_rdy_si, bus.ch_valid, leds}), 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 4; i++) begin
            start = dlv_n;
            send_frame(vecs[i].frame, vecs[i].len, $sformatf("vec%0d", i));
            finish_status(vecs[i].exp_st, vecs[i].exp_leds, $sformatf("vec%0d", i), 500, cyc);
            check_dlv(start, vecs[i].exp_n, vecs[i].exp_data, vecs[i].exp_vec,
                      $sformatf("vec%0d", i));
            @(posedge clk);
            #1;
        end
        base = vecs[3].exp_leds;

        // Backpressure: channel 0 stalls for 100 cycles holding 5A.
        bus.ch_ready = 4'b1110;
        start = dlv_n;
        send_frame(64'hA5_00_02_5A_00_00_00_00, 4, "bp");
        present(8'h5B);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!(bus.ch_data == 8'h5A && bus.ch_valid == 4'b0001 &&
                  !bus.rx_ack_si && !bus.tx_rdy_si)) bad++;
        end
        chk("bp stall hold", 32'(bad), 32'd0);
        @(posedge clk);
        #1 bus.ch_ready = 4'b1111;
        wait_ack(200, "bp 5B");
`ifdef CHECKSUM_EN
        send_frame(64'h03_00_00_00_00_00_00_00, 1, "bp csum");
`endif
        finish_status(ST_OK, base + 8'd1, "bp", 500, cyc);
        check_dlv(start, 2, 32'h5A_5B_00_00, 4'b0001, "bp");
        @(posedge clk);
        #1;

        // Timeout: sync and channel, then silence.
        send_frame(64'hA5_02_00_00_00_00_00_00, 2, "tmo");
        finish_status(ST_TIMEOUT, base + 8'd1, "tmo", TB_TMO + 100, cyc);
        chk("tmo latency", 32'(cyc >= TB_TMO && cyc <= TB_TMO + 2), 32'd1);
        @(posedge clk);
        #1;
        send_frame(vecs[3].frame, vecs[3].len, "post tmo");
        finish_status(ST_OK, base + 8'd2, "post tmo", 500, cyc);
        @(posedge clk);
        #1;

        // Reset mid-payload while channel 0 holds a byte.
        bus.ch_ready = 4'b1110;
        send_frame(64'hA5_00_03_11_00_00_00_00, 4, "rst pre");
        @(negedge clk);
        chk("rst pre held", 32'({bus.ch_valid, bus.ch_data}), 32'({4'b0001, 8'h11}));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst async outputs",
            32'({bus.rx_ack_si, bus.tx_rdy_si, bus.tx_data_si, bus.ch_valid, bus.ch_data}), 32'd0);
        chk("rst async leds", 32'(leds), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        bus.ch_ready = 4'b1111;
        @(posedge clk);
        #1;
        start = dlv_n;
`ifdef CHECKSUM_EN
        send_frame(64'h00_FF_A5_00_01_77_76_00, 7, "resync");
`else
        send_frame(64'h00_FF_A5_00_01_77_00_00, 6, "resync");
`endif
        finish_status(ST_OK, 8'd1, "resync", 500, cyc);
        check_dlv(start, 1, 32'h77_00_00_00, 4'b0001, "resync");

        chk("rx_ack back-to-back", 32'(ack_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
